// File: rtl/jacobi_sequencer.sv
`timescale 1ns/1ps
// jacobi_sequencer
// Controls a scan-chained array of Jacobi nodes through a full job:
// the host loads one word per node, the array relaxes for a given number
// of iterations, and the result is shifted back out to the host.
// Unloaded words are fed back into the chain tail, so the array still
// holds its values after the job.
//
// Ports:
//   Clk, Reset        clock and synchronous active-high reset
//   Start, Iters      job request and iteration count (captured on Start in IDLE)
//   LoadValid/Ready   host load handshake, word on LoadData
//   ScanEnable        shift the whole chain one node toward node 0
//   ScanData          word entering the chain tail (node NODES-1)
//   ScanIn            word leaving the chain head (node 0)
//   Enable            Jacobi compute enable to the interior nodes
//   UnloadValid/Ready host unload handshake, word on UnloadData
//   Busy, Done        job in progress, one-cycle completion pulse
module jacobi_sequencer #(
  parameter int WIDTH  = 8,
  parameter int NODES  = 16,
  parameter int CWIDTH = 7
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [CWIDTH-1:0] Iters,
  input  logic              LoadValid,
  input  logic [WIDTH-1:0]  LoadData,
  output logic              LoadReady,
  output logic              ScanEnable,
  output logic [WIDTH-1:0]  ScanData,
  input  logic [WIDTH-1:0]  ScanIn,
  output logic              Enable,
  output logic              UnloadValid,
  output logic [WIDTH-1:0]  UnloadData,
  input  logic              UnloadReady,
  output logic              Busy,
  output logic              Done
);

  // One spare bit so the counter can represent NODES itself.
  localparam int SW = $clog2(NODES) + 1;
  localparam logic [SW-1:0] LASTSHIFT = SW'(NODES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, UNLOAD, DONE} seqState;

  seqState           state, nextState;
  logic [SW-1:0]     shiftCount, nextShiftCount;
  logic [CWIDTH-1:0] iterCount, nextIterCount;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      shiftCount <= '0;
      iterCount  <= '0;
    end else begin
      state      <= nextState;
      shiftCount <= nextShiftCount;
      iterCount  <= nextIterCount;
    end
  end

  always_comb begin
    nextState      = state;
    nextShiftCount = shiftCount;
    nextIterCount  = iterCount;
    LoadReady      = 1'b0;
    ScanEnable     = 1'b0;
    ScanData       = '0;
    Enable         = 1'b0;
    UnloadValid    = 1'b0;
    UnloadData     = '0;
    Done           = 1'b0;

    case (state)
      IDLE: begin
        if (Start) begin
          nextIterCount  = Iters;
          nextShiftCount = '0;
          nextState      = LOAD;
        end
      end

      // Words pushed out of node 0 while loading are stale and simply dropped.
      LOAD: begin
        LoadReady  = 1'b1;
        ScanData   = LoadData;
        ScanEnable = LoadValid;
        if (LoadValid) begin
          if (shiftCount == LASTSHIFT) begin
            nextShiftCount = '0;
            nextState      = (iterCount != '0) ? RUN : UNLOAD;
          end else begin
            nextShiftCount = shiftCount + 1'b1;
          end
        end
      end

      // RUN is only entered with a nonzero count, so Enable stays up for
      // exactly the captured number of cycles.
      RUN: begin
        Enable = 1'b1;
        if (iterCount != '0) nextIterCount = iterCount - 1'b1;
        if (iterCount <= CWIDTH'(1)) nextState = UNLOAD;
      end

      // Recirculating the head word back into the tail restores the array
      // after a full pass.
      UNLOAD: begin
        UnloadValid = 1'b1;
        UnloadData  = ScanIn;
        ScanData    = ScanIn;
        ScanEnable  = UnloadReady;
        if (UnloadReady) begin
          if (shiftCount == LASTSHIFT) begin
            nextShiftCount = '0;
            nextState      = DONE;
          end else begin
            nextShiftCount = shiftCount + 1'b1;
          end
        end
      end

      DONE: begin
        Done      = 1'b1;
        nextState = IDLE;
      end

      default: nextState = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_jacobi_sequencer.sv
`timescale 1ns/1ps
// tb_jacobi_sequencer
// Bench for jacobi_sequencer. Models a 4x4 node array as a scan chain
// (node 0 at the head) with Jacobi averaging on the four interior nodes,
// drives full jobs through it and checks the returned words and handshakes.
module tb_jacobi_sequencer;

  localparam int WIDTH  = 8;
  localparam int NODES  = 16;
  localparam int CWIDTH = 7;

  logic              Clk;
  logic              Reset;
  logic              Start;
  logic [CWIDTH-1:0] Iters;
  logic              LoadValid;
  logic [WIDTH-1:0]  LoadData;
  logic              LoadReady;
  logic              ScanEnable;
  logic [WIDTH-1:0]  ScanData;
  logic [WIDTH-1:0]  ScanIn;
  logic              Enable;
  logic              UnloadValid;
  logic [WIDTH-1:0]  UnloadData;
  logic              UnloadReady;
  logic              Busy;
  logic              Done;

  int vecCount  = 0;
  int missCount = 0;

  logic [WIDTH-1:0] chain     [NODES];
  logic [WIDTH-1:0] loadWords [NODES];
  logic [WIDTH-1:0] expWords  [NODES];

  jacobi_sequencer #(.WIDTH(WIDTH), .NODES(NODES), .CWIDTH(CWIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Iters(Iters),
    .LoadValid(LoadValid), .LoadData(LoadData), .LoadReady(LoadReady),
    .ScanEnable(ScanEnable), .ScanData(ScanData), .ScanIn(ScanIn),
    .Enable(Enable), .UnloadValid(UnloadValid), .UnloadData(UnloadData),
    .UnloadReady(UnloadReady), .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Node array: shifting moves every word one node toward the head; the
  // compute step replaces each interior node with the mean of its four
  // neighbours, all from the previous cycle's values.
  always @(posedge Clk) begin
    if (ScanEnable) begin
      for (int i = 0; i < NODES - 1; i++) chain[i] <= chain[i + 1];
      chain[NODES - 1] <= ScanData;
    end else if (Enable) begin
      for (int r = 1; r < 3; r++) begin
        for (int c = 1; c < 3; c++) begin
          chain[r*4 + c] <= WIDTH'((int'(chain[r*4 + c - 4]) + int'(chain[r*4 + c + 4]) +
                                    int'(chain[r*4 + c - 1]) + int'(chain[r*4 + c + 1])) >> 2);
        end
      end
    end
  end

  assign ScanIn = chain[0];

  typedef struct {
    logic             reset;
    logic             start;
    logic             loadValid;
    logic [WIDTH-1:0] loadData;
    logic             expBusy;
    logic             expLoadReady;
    logic             expScanEnable;
    logic [WIDTH-1:0] expScanData;
  } vecT;

  vecT vec [8];

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit isBoundary(input int k);
    return (k / 4 == 0) || (k / 4 == 3) || (k % 4 == 0) || (k % 4 == 3);
  endfunction

  task automatic setGrid(input logic [WIDTH-1:0] edgeVal, input logic [WIDTH-1:0] inVal,
                         input logic [WIDTH-1:0] expIn);
    for (int k = 0; k < NODES; k++) begin
      loadWords[k] = isBoundary(k) ? edgeVal : inVal;
      expWords[k]  = isBoundary(k) ? edgeVal : expIn;
    end
  endtask

  task automatic setRamp(input int base);
    for (int k = 0; k < NODES; k++) begin
      loadWords[k] = WIDTH'(base + k);
      expWords[k]  = WIDTH'(base + k);
    end
  endtask

  // Drives one whole job and checks it: handshakes, Enable length,
  // returned words, single Done pulse and Busy release.
  task automatic applyStimulus(input string tag, input logic [CWIDTH-1:0] iters,
                               input bit loadToggle, input bit unloadToggle,
                               input bit pokeStart, input int expEnable);
    int loaded = 0, unloaded = 0, cyc = 0, enCycles = 0, doneCount = 0;
    int seBad = 0, bothHigh = 0, extraDone = 0;
    bit phase = 1'b0;
    logic [WIDTH-1:0] got [NODES];
    for (int k = 0; k < NODES; k++) got[k] = '0;

    Iters = iters;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;

    while (doneCount == 0 && cyc < 2000) begin
      LoadValid   = loadToggle ? !phase : 1'b1;
      LoadData    = (loaded < NODES) ? loadWords[loaded] : '0;
      UnloadReady = unloadToggle ? phase : 1'b1;
      Start       = pokeStart && Enable;
      #1;
      if (ScanEnable !== ((LoadValid && LoadReady) || (UnloadValid && UnloadReady))) seBad++;
      if (ScanEnable && Enable) bothHigh++;
      if (LoadValid && LoadReady) loaded++;
      if (UnloadValid && UnloadReady) begin
        if (unloaded < NODES) got[unloaded] = UnloadData;
        unloaded++;
      end
      if (Enable) enCycles++;
      if (Done) doneCount++;
      @(posedge Clk); #1;
      phase = !phase;
      cyc++;
    end
    Start = 1'b0; LoadValid = 1'b0; UnloadReady = 1'b0;
    #1;

    checkOutput({tag, " doneSeen"}, doneCount, 1);
    checkOutput({tag, " busyAfterDone"}, int'(Busy), 0);
    checkOutput({tag, " doneOneCycle"}, int'(Done), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      if (Done) extraDone++;
    end
    checkOutput({tag, " extraDone"}, extraDone, 0);
    checkOutput({tag, " loadedWords"}, loaded, NODES);
    checkOutput({tag, " unloadedWords"}, unloaded, NODES);
    checkOutput({tag, " enableCycles"}, enCycles, expEnable);
    checkOutput({tag, " scanEnableVsHandshake"}, seBad, 0);
    checkOutput({tag, " scanAndEnable"}, bothHigh, 0);
    for (int k = 0; k < NODES; k++)
      checkOutput($sformatf("%s word%0d", tag, k), int'(got[k]), int'(expWords[k]));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " Busy"}, int'(Busy), 0);
    checkOutput({tag, " Done"}, int'(Done), 0);
    checkOutput({tag, " LoadReady"}, int'(LoadReady), 0);
    checkOutput({tag, " UnloadValid"}, int'(UnloadValid), 0);
    checkOutput({tag, " Enable"}, int'(Enable), 0);
    checkOutput({tag, " ScanEnable"}, int'(ScanEnable), 0);
    checkOutput({tag, " ScanData"}, int'(ScanData), 0);
  endtask

  initial begin
    // Single-cycle protocol trace: idle, start, stall, handshake, reset
    // priority over a handshake and over Start.
    vec[0] = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00};
    vec[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vec[2] = '{1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h11};
    vec[3] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22};
    vec[4] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33};
    vec[5] = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00};
    vec[6] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vec[7] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00};

    Reset = 1'b1; Start = 1'b0; Iters = '0;
    LoadValid = 1'b0; LoadData = '0; UnloadReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checkAllZero("reset");
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      Reset     = vec[i].reset;
      Start     = vec[i].start;
      LoadValid = vec[i].loadValid;
      LoadData  = vec[i].loadData;
      #1;
      checkOutput($sformatf("vec%0d Busy", i), int'(Busy), int'(vec[i].expBusy));
      checkOutput($sformatf("vec%0d LoadReady", i), int'(LoadReady), int'(vec[i].expLoadReady));
      checkOutput($sformatf("vec%0d ScanEnable", i), int'(ScanEnable), int'(vec[i].expScanEnable));
      checkOutput($sformatf("vec%0d ScanData", i), int'(ScanData), int'(vec[i].expScanData));
      @(posedge Clk); #1;
    end
    Reset = 1'b0; Start = 1'b0; LoadValid = 1'b0; LoadData = '0;

    // Plain load/unload, values 1..16 come back in order.
    setRamp(1);
    applyStimulus("basic", 7'd0, 1'b0, 1'b0, 1'b0, 0);

    // One iteration: interior nodes see two 64 neighbours -> 32.
    setGrid(8'd64, 8'd0, 8'd32);
    applyStimulus("iter1", 7'd1, 1'b0, 1'b0, 1'b0, 1);

    // Three iterations: 0 -> 32 -> 48 -> 56.
    setGrid(8'd64, 8'd0, 8'd56);
    applyStimulus("iter3", 7'd3, 1'b0, 1'b0, 1'b0, 3);

    setRamp(100);
    applyStimulus("backpressure", 7'd0, 1'b1, 1'b1, 1'b0, 0);

    // Uniform array is a fixed point of the averaging.
    setGrid(8'd7, 8'd7, 8'd7);
    applyStimulus("startInRun", 7'd5, 1'b0, 1'b0, 1'b1, 5);

    // Reset after five load handshakes.
    Iters = 7'd2; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; LoadValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      LoadData = WIDTH'(i + 50);
      @(posedge Clk); #1;
    end
    checkOutput("midJob loadReadyBeforeReset", int'(LoadReady), 1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    checkAllZero("midJobReset");
    Reset = 1'b0; LoadValid = 1'b0;

    setRamp(200);
    applyStimulus("afterReset", 7'd0, 1'b0, 1'b0, 1'b0, 0);

    // Interior settles at 63 with integer averaging.
    setGrid(8'd64, 8'd0, 8'd63);
    applyStimulus("iter127", 7'd127, 1'b0, 1'b0, 1'b0, 127);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
